// File: rtl/pixel_frame_ctrl.sv
// ---------------------------------------------------------------------------
// pixel_frame_ctrl
//
// Frame sequencer for the pixel array. After an init request it walks
// ERASE -> EXPOSE -> CONVERT -> READ1 -> READ2 and then returns to IDLE.
// Each phase drives its own control line. During CONVERT it also produces
// the shared ADC ramp count. The exposure setting can be adjusted only
// while the sequencer is idle.
//
// Ports
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   init        frame start request (rising-edge sensitive)
//   exp_inc     exposure increment request (rising-edge sensitive)
//   exp_dec     exposure decrement request (rising-edge sensitive)
//   erase       pixel erase control (high in ERASE only)
//   expose      pixel expose control (high in EXPOSE only)
//   convert     ADC conversion active (high in CONVERT only)
//   read1       readout phase 1 (high in READ1 only)
//   read2       readout phase 2 (high in READ2 only)
//   adc_count   ADC ramp value, counts 0..2^ADC_BITS-1 during CONVERT
//   exp_time    current exposure setting in EXP_UNIT-cycle units
//   busy        high whenever the sequencer is not idle
//   frame_done  one-cycle pulse in the first IDLE cycle after READ2
// ---------------------------------------------------------------------------
module pixel_frame_ctrl #(
    parameter int ERASE_CYCLES = 5,
    parameter int EXP_UNIT     = 4,
    parameter int EXP_MIN      = 2,
    parameter int EXP_MAX      = 30,
    parameter int EXP_RESET    = 16,
    parameter int ADC_BITS     = 8,
    parameter int READ_CYCLES  = 5
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                init,
    input  logic                exp_inc,
    input  logic                exp_dec,
    output logic                erase,
    output logic                expose,
    output logic                convert,
    output logic                read1,
    output logic                read2,
    output logic [ADC_BITS-1:0] adc_count,
    output logic [4:0]          exp_time,
    output logic                busy,
    output logic                frame_done
);

    // The phase counter must hold the longest duration-1. That is the
    // conversion length or the longest exposure, whichever is larger.
    // 16 bits covers every sensible parameter choice.
    localparam int CNT_W = 16;

    localparam logic [CNT_W-1:0] ERASE_LOAD   = CNT_W'(ERASE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CONVERT_LOAD = CNT_W'((1 << ADC_BITS) - 1);
    localparam logic [CNT_W-1:0] READ_LOAD    = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] EXP_UNIT_W   = CNT_W'(EXP_UNIT);
    localparam logic [4:0]       EXP_MIN_V    = 5'(EXP_MIN);
    localparam logic [4:0]       EXP_MAX_V    = 5'(EXP_MAX);
    localparam logic [4:0]       EXP_RESET_V  = 5'(EXP_RESET);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERASE,
        ST_EXPOSE,
        ST_CONVERT,
        ST_READ1,
        ST_READ2
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADC_BITS-1:0]  adc_q, adc_d;
    logic [4:0]           exp_q, exp_d;
    logic                 done_q, done_d;
    logic                 init_prev_q, init_prev_d;
    logic                 inc_prev_q, inc_prev_d;
    logic                 dec_prev_q, dec_prev_d;

    logic                 init_edge;
    logic                 inc_edge;
    logic                 dec_edge;
    logic                 phase_end;
    logic [CNT_W-1:0]     expose_load;

    // A request counts only on the cycle where its input is 1 and the
    // previous sample was 0. A held level therefore produces one event.
    assign init_edge = init    & ~init_prev_q;
    assign inc_edge  = exp_inc & ~inc_prev_q;
    assign dec_edge  = exp_dec & ~dec_prev_q;

    assign phase_end   = (cnt_q == '0);
    assign expose_load = (CNT_W'(exp_q) * EXP_UNIT_W) - CNT_W'(1);

    // Next-state logic. The counter is loaded with duration-1 when a phase
    // is entered, and the state advances on the edge where it reads zero.
    // exp_q cannot change outside IDLE. Loading the EXPOSE count from it
    // therefore fixes the exposure of the frame already in flight.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        adc_d       = '0;
        exp_d       = exp_q;
        done_d      = 1'b0;
        init_prev_d = init;
        inc_prev_d  = exp_inc;
        dec_prev_d  = exp_dec;

        case (state_q)
            ST_IDLE: begin
                if (inc_edge && !dec_edge && (exp_q < EXP_MAX_V)) begin
                    exp_d = exp_q + 5'd1;
                end else if (dec_edge && !inc_edge && (exp_q > EXP_MIN_V)) begin
                    exp_d = exp_q - 5'd1;
                end
                if (init_edge) begin
                    state_d = ST_ERASE;
                    cnt_d   = ERASE_LOAD;
                end
            end
            ST_ERASE: begin
                if (phase_end) begin
                    state_d = ST_EXPOSE;
                    cnt_d   = expose_load;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_EXPOSE: begin
                if (phase_end) begin
                    state_d = ST_CONVERT;
                    cnt_d   = CONVERT_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CONVERT: begin
                if (phase_end) begin
                    state_d = ST_READ1;
                    cnt_d   = READ_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    adc_d = adc_q + ADC_BITS'(1);
                end
            end
            ST_READ1: begin
                if (phase_end) begin
                    state_d = ST_READ2;
                    cnt_d   = READ_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_READ2: begin
                if (phase_end) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The state and data registers. Reset clears everything except the
    // exposure setting, which returns to its power-on default.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            adc_q       <= '0;
            exp_q       <= EXP_RESET_V;
            done_q      <= 1'b0;
            init_prev_q <= 1'b0;
            inc_prev_q  <= 1'b0;
            dec_prev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            adc_q       <= adc_d;
            exp_q       <= exp_d;
            done_q      <= done_d;
            init_prev_q <= init_prev_d;
            inc_prev_q  <= inc_prev_d;
            dec_prev_q  <= dec_prev_d;
        end
    end

    // The control lines are Moore outputs decoded from the state register.
    // As a result, an asynchronous reset drops them immediately.
    assign erase      = (state_q == ST_ERASE);
    assign expose     = (state_q == ST_EXPOSE);
    assign convert    = (state_q == ST_CONVERT);
    assign read1      = (state_q == ST_READ1);
    assign read2      = (state_q == ST_READ2);
    assign busy       = (state_q != ST_IDLE);
    assign adc_count  = adc_q;
    assign exp_time   = exp_q;
    assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_frame_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pixel_frame_ctrl
//
// Directed testbench for pixel_frame_ctrl. A frame-timeline model predicts
// every output on every clock cycle. The expected phase is derived
// arithmetically from the cycle offset since the frame started. Literal
// phase lengths and exposure settings pin the model itself.
// ---------------------------------------------------------------------------
module tb_pixel_frame_ctrl;

    localparam int ERASE_C = 5;
    localparam int UNIT    = 4;
    localparam int CONV_C  = 256;
    localparam int READ_C  = 5;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       init    = 1'b0;
    logic       exp_inc = 1'b0;
    logic       exp_dec = 1'b0;
    logic       erase, expose, convert, read1, read2, busy, frame_done;
    logic [7:0] adc_count;
    logic [4:0] exp_time;

    int nchk = 0;
    int nerr = 0;

    pixel_frame_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .init       (init),
        .exp_inc    (exp_inc),
        .exp_dec    (exp_dec),
        .erase      (erase),
        .expose     (expose),
        .convert    (convert),
        .read1      (read1),
        .read2      (read2),
        .adc_count  (adc_count),
        .exp_time   (exp_time),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Compares one observed value against its required value and counts it.
    task automatic checkOutput(input string name, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Drives all three request inputs and holds them for a number of cycles.
    task automatic applyStimulus(input logic i, input logic u, input logic d, input int cycles);
        init    = i;
        exp_inc = u;
        exp_dec = d;
        repeat (cycles) @(negedge clk);
    endtask

    function automatic int frameLen(input int e);
        return ERASE_C + e * UNIT + CONV_C + 2 * READ_C;
    endfunction

    // Frame-timeline model: it records when the current frame began and
    // which exposure that frame uses. All outputs are derived from the
    // cycle offset since that start.
    int   m_cyc    = 0;
    int   m_start  = 0;
    int   m_fexp   = 16;
    int   m_exp    = 16;
    bit   m_active = 1'b0;
    bit   m_pi = 1'b0, m_pu = 1'b0, m_pd = 1'b0;
    bit   m_idle, m_ei, m_eu, m_ed;
    int   m_t, m_tot, e_adc;
    logic [6:0] e_ctrl, a_ctrl;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_cyc    = 0;
            m_active = 1'b0;
            m_exp    = 16;
            m_pi     = 1'b0;
            m_pu     = 1'b0;
            m_pd     = 1'b0;
        end else begin
            m_idle = !m_active || ((m_cyc - m_start) >= frameLen(m_fexp));
            m_ei   = init && !m_pi;
            m_eu   = exp_inc && !m_pu;
            m_ed   = exp_dec && !m_pd;
            if (m_idle) begin
                if (m_eu && !m_ed) m_exp = (m_exp + 1 > 30) ? 30 : m_exp + 1;
                else if (m_ed && !m_eu) m_exp = (m_exp - 1 < 2) ? 2 : m_exp - 1;
                if (m_ei) begin
                    m_active = 1'b1;
                    m_start  = m_cyc + 1;
                    m_fexp   = m_exp;
                end
            end
            m_pi  = init;
            m_pu  = exp_inc;
            m_pd  = exp_dec;
            m_cyc = m_cyc + 1;
        end
        #1;
        e_ctrl = '0;
        e_adc  = 0;
        m_t    = m_cyc - m_start;
        m_tot  = frameLen(m_fexp);
        if (!reset && m_active && m_t < m_tot) begin
            e_ctrl[1] = 1'b1;
            if (m_t < ERASE_C) e_ctrl[6] = 1'b1;
            else if (m_t < ERASE_C + m_fexp * UNIT) e_ctrl[5] = 1'b1;
            else if (m_t < ERASE_C + m_fexp * UNIT + CONV_C) begin
                e_ctrl[4] = 1'b1;
                e_adc     = m_t - ERASE_C - m_fexp * UNIT;
            end
            else if (m_t < m_tot - READ_C) e_ctrl[3] = 1'b1;
            else e_ctrl[2] = 1'b1;
        end
        if (!reset && m_active && m_t == m_tot) e_ctrl[0] = 1'b1;
        a_ctrl = {erase, expose, convert, read1, read2, busy, frame_done};
        checkOutput("ctrl_vector", int'(a_ctrl), int'(e_ctrl));
        checkOutput("adc_count", int'(adc_count), e_adc);
        checkOutput("exp_time", int'(exp_time), m_exp);
    end

    // Starts a frame and measures every phase length, then checks each one
    // against the required literal values. It can optionally poke requests
    // while the frame is busy, or leave init high to chain the next frame.
    task automatic runFrame(input string tag, input int exp_cycles, input bit poke_inc,
                            input bit poke_init, input bit chain);
        int n_er = 0, n_ex = 0, n_cv = 0, n_r1 = 0, n_r2 = 0;
        int done_at = -1, adc_last = -1;
        bit first_erase;
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        first_erase = erase;
        for (int k = 0; k < 2000; k++) begin
            if (erase)   n_er++;
            if (expose)  n_ex++;
            if (convert) begin n_cv++; adc_last = int'(adc_count); end
            if (read1)   n_r1++;
            if (read2)   n_r2++;
            exp_inc = 1'b0;
            init    = 1'b0;
            if (frame_done) begin
                done_at = k;
                checkOutput({tag, "_busy_at_done"}, int'(busy), 0);
                if (chain) init = 1'b1;
                break;
            end
            if (poke_inc && expose && n_ex == 10) exp_inc = 1'b1;
            if (poke_init && convert && n_cv == 50) init = 1'b1;
            @(negedge clk);
        end
        checkOutput({tag, "_erase_first"}, int'(first_erase), 1);
        checkOutput({tag, "_erase_len"}, n_er, 5);
        checkOutput({tag, "_expose_len"}, n_ex, exp_cycles);
        checkOutput({tag, "_convert_len"}, n_cv, 256);
        checkOutput({tag, "_read1_len"}, n_r1, 5);
        checkOutput({tag, "_read2_len"}, n_r2, 5);
        checkOutput({tag, "_adc_last"}, adc_last, 255);
        checkOutput({tag, "_done_offset"}, done_at, 5 + exp_cycles + 256 + 10);
    endtask

    initial begin
        bit found;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("reset_ctrl", int'({erase, expose, convert, read1, read2, busy, frame_done}), 0);
        checkOutput("reset_exp_time", int'(exp_time), 16);
        checkOutput("reset_adc", int'(adc_count), 0);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 2);

        runFrame("default", 64, 0, 0, 0);
        applyStimulus(0, 0, 0, 3);

        repeat (20) begin
            applyStimulus(0, 1, 0, 1);
            applyStimulus(0, 0, 0, 1);
        end
        checkOutput("inc_saturate", int'(exp_time), 30);
        runFrame("exp_max", 120, 0, 0, 0);
        applyStimulus(0, 0, 0, 3);

        repeat (40) begin
            applyStimulus(0, 0, 1, 1);
            applyStimulus(0, 0, 0, 1);
        end
        checkOutput("dec_saturate", int'(exp_time), 2);
        runFrame("exp_min", 8, 0, 0, 0);
        applyStimulus(0, 0, 0, 3);

        applyStimulus(0, 1, 0, 50);
        applyStimulus(0, 0, 0, 2);
        checkOutput("inc_held", int'(exp_time), 3);

        applyStimulus(0, 1, 1, 1);
        applyStimulus(0, 0, 0, 2);
        checkOutput("inc_dec_same_cycle", int'(exp_time), 3);

        runFrame("busy_pokes", 12, 1, 1, 0);
        applyStimulus(0, 0, 0, 20);
        checkOutput("no_second_frame", int'(busy), 0);
        checkOutput("exp_after_busy_inc", int'(exp_time), 3);

        repeat (17) begin
            applyStimulus(0, 1, 0, 1);
            applyStimulus(0, 0, 0, 1);
        end
        checkOutput("exp_set_20", int'(exp_time), 20);
        applyStimulus(1, 0, 0, 1);
        init  = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            if (convert && adc_count == 8'd100) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checkOutput("reached_adc_100", int'(found), 1);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_reset_ctrl", int'({erase, expose, convert, read1, read2, busy, frame_done}), 0);
        checkOutput("async_reset_adc", int'(adc_count), 0);
        checkOutput("async_reset_exp", int'(exp_time), 16);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(0, 0, 0, 2);

        runFrame("after_reset", 64, 0, 0, 1);
        runFrame("back_to_back", 64, 0, 0, 0);
        applyStimulus(0, 0, 0, 3);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
